// File: rtl/ms_interval_timer.sv
// Millisecond interval timer driven by an external 1 ms clock-enable strobe.
// Supports one-shot and auto-reload operation, with a completed-period counter.
module ms_interval_timer #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce1ms,
  input  logic          start,
  input  logic          abort,
  input  logic          periodic,
  input  logic [W-1:0]  period_ms,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  elapsed_ms,
  output logic [CW-1:0] periods
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  period_q, period_d;
  logic          periodic_q, periodic_d;
  logic [W-1:0]  elapsed_q, elapsed_d;
  logic [CW-1:0] periods_q, periods_d;
  logic          done_q, done_d;
  logic [W-1:0]  tickCount;

  assign tickCount = elapsed_q + W'(1);

  // Priority is abort, then start, then a tick; a start swallows any coincident tick.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    elapsed_d  = elapsed_q;
    periods_d  = periods_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      elapsed_d = '0;
    end else if (start) begin
      period_d   = period_ms;
      periodic_d = periodic;
      elapsed_d  = '0;
      if (period_ms == '0) begin
        state_d   = IDLE;
        done_d    = 1'b1;
        periods_d = CW'(1);
      end else begin
        state_d   = RUN;
        periods_d = '0;
      end
    end else if (state_q == RUN && ce1ms) begin
      if (tickCount == period_q) begin
        done_d    = 1'b1;
        periods_d = periods_q + CW'(1);
        if (periodic_q) begin
          elapsed_d = '0;
        end else begin
          state_d   = IDLE;
          elapsed_d = tickCount;
        end
      end else begin
        elapsed_d = tickCount;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      period_q   <= '0;
      periodic_q <= 1'b0;
      elapsed_q  <= '0;
      periods_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      elapsed_q  <= elapsed_d;
      periods_q  <= periods_d;
      done_q     <= done_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign elapsed_ms = elapsed_q;
  assign periods    = periods_q;

endmodule

// File: tb/tb_ms_interval_timer.sv
// Directed bench for ms_interval_timer; ce1ms pulses on every 4th applied edge.
// A second instance with CW=2 shares the stimulus to observe the periods wrap.
module tb_ms_interval_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce1ms = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        periodic = 1'b0;
  logic [15:0] periodMs = '0;

  logic        busy, done;
  logic [15:0] elapsedMs;
  logic [7:0]  periods;
  logic        busyW, doneW;
  logic [15:0] elapsedMsW;
  logic [1:0]  periodsW;

  int cyc = 0;
  int checkCount = 0;
  int errorCount = 0;

  ms_interval_timer #(.W(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .start(start), .abort(abort),
    .periodic(periodic), .period_ms(periodMs), .busy(busy), .done(done),
    .elapsed_ms(elapsedMs), .periods(periods)
  );

  ms_interval_timer #(.W(16), .CW(2)) dutW (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .start(start), .abort(abort),
    .periodic(periodic), .period_ms(periodMs), .busy(busyW), .done(doneW),
    .elapsed_ms(elapsedMsW), .periods(periodsW)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // One clock edge: inputs presented for edge number cyc, outputs sampled 1 time unit after it.
  task automatic applyStimulus(input logic s, input logic a, input logic per, input logic [15:0] p);
    cyc++;
    start    = s;
    abort    = a;
    periodic = per;
    periodMs = p;
    ce1ms    = (cyc % 4 == 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    ce1ms = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #1;
    applyReset();
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_elapsed", 32'(elapsedMs), 0);
    checkOutput("rst_periods", 32'(periods), 0);

    // 1: one-shot P=3 started at edge 1, ticks at 4/8/12
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(k == 1, 1'b0, 1'b0, 16'd3);
      checkOutput("t1_busy", 32'(busy), (k < 12) ? 1 : 0);
      checkOutput("t1_done", 32'(done), (k == 12) ? 1 : 0);
      checkOutput("t1_elapsed", 32'(elapsedMs), (k < 4) ? 0 : (k < 8) ? 1 : (k < 12) ? 2 : 3);
      checkOutput("t1_periods", 32'(periods), (k >= 12) ? 1 : 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd3);
    checkOutput("t1_midrun_elapsed", 32'(elapsedMs), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t1_arst_busy", 32'(busy), 0);
    checkOutput("t1_arst_elapsed", 32'(elapsedMs), 0);
    #2 rst = 1'b0;
    cyc = 0;

    // 2: periodic P=2, done after edges 8/16/24, then async reset
    for (int k = 1; k <= 26; k++) begin
      applyStimulus(k == 1, 1'b0, 1'b1, 16'd2);
      checkOutput("t2_busy", 32'(busy), 1);
      checkOutput("t2_done", 32'(done), (k == 8 || k == 16 || k == 24) ? 1 : 0);
      checkOutput("t2_elapsed", 32'(elapsedMs), ((k / 4) % 2 == 1) ? 1 : 0);
      checkOutput("t2_periods", 32'(periods), k / 8);
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("t2_arst_busy", 32'(busy), 0);
    checkOutput("t2_arst_done", 32'(done), 0);
    checkOutput("t2_arst_elapsed", 32'(elapsedMs), 0);
    checkOutput("t2_arst_periods", 32'(periods), 0);
    #2 rst = 1'b0;
    cyc = 0;

    // 3: start coincident with tick at edge 4, P=1; then a zero period
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(k == 4, 1'b0, 1'b0, 16'd1);
      checkOutput("t3_busy", 32'(busy), (k >= 4 && k < 8) ? 1 : 0);
      checkOutput("t3_done", 32'(done), (k == 8) ? 1 : 0);
      checkOutput("t3_elapsed", 32'(elapsedMs), (k >= 8) ? 1 : 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd0);
    checkOutput("t3_zero_done", 32'(done), 1);
    checkOutput("t3_zero_busy", 32'(busy), 0);
    checkOutput("t3_zero_periods", 32'(periods), 1);
    checkOutput("t3_zero_elapsed", 32'(elapsedMs), 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'd0);
      checkOutput("t3_zero_after_done", 32'(done), 0);
      checkOutput("t3_zero_after_busy", 32'(busy), 0);
    end
    applyReset();

    // 4: abort on the completing tick, then start+abort together in idle
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(k == 1, k == 8, 1'b0, 16'd2);
      checkOutput("t4_done", 32'(done), 0);
      checkOutput("t4_busy", 32'(busy), (k < 8) ? 1 : 0);
      checkOutput("t4_elapsed", 32'(elapsedMs), (k >= 4 && k < 8) ? 1 : 0);
      checkOutput("t4_periods", 32'(periods), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd3);
    checkOutput("t4_startabort_busy", 32'(busy), 0);
    checkOutput("t4_startabort_done", 32'(done), 0);
    applyReset();

    // 5: P=5, restart with P=2 at edge 13 after three ticks
    for (int k = 1; k <= 21; k++) begin
      applyStimulus(k == 1 || k == 13, 1'b0, 1'b0, (k < 13) ? 16'd5 : 16'd2);
      checkOutput("t5_done", 32'(done), (k == 20) ? 1 : 0);
      checkOutput("t5_busy", 32'(busy), (k < 20) ? 1 : 0);
      checkOutput("t5_elapsed", 32'(elapsedMs),
                  (k < 4) ? 0 : (k < 8) ? 1 : (k < 12) ? 2 : (k < 13) ? 3 :
                  (k < 16) ? 0 : (k < 20) ? 1 : 2);
    end
    applyReset();

    // 6: periodic P=1, five periods; the CW=2 instance wraps to 0
    for (int k = 1; k <= 21; k++) begin
      applyStimulus(k == 1, 1'b0, 1'b1, 16'd1);
      checkOutput("t6_done", 32'(done), (k % 4 == 0) ? 1 : 0);
      checkOutput("t6_elapsed", 32'(elapsedMs), 0);
      checkOutput("t6_periods", 32'(periods), k / 4);
      checkOutput("t6_periods_wrap", 32'(periodsW), (k / 4) % 4);
      checkOutput("t6_busy_wrap", 32'(busyW), 1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
